// File: rtl/memory_pkg.sv
// Shared types and default widths for the memory_ctrl slice.
package memory_pkg;

    localparam int unsigned MEM_DWIDTH = 8;
    localparam int unsigned MEM_AWIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_SETUP  = 3'd1,
        ST_WR_STROBE = 3'd2,
        ST_WR_HOLD   = 3'd3,
        ST_RD_ACTIVE = 3'd4
    } mem_ctrl_state_t;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_op_t;

    // Larger of two unsigned values; used to size the strobe counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/memory_ctrl_if.sv
// Host request/response handshake between an initiator and memory_ctrl.
interface memory_ctrl_if
    import memory_pkg::*;
#(
    parameter int unsigned DWIDTH = MEM_DWIDTH,
    parameter int unsigned AWIDTH = MEM_AWIDTH
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_bus_io.sv
// Tri-state driver for the shared memory data bus plus the sampled bus value.
module mem_bus_io #(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              oe,
    input  logic [DWIDTH-1:0] dout,
    output logic [DWIDTH-1:0] din,
    inout  wire  [DWIDTH-1:0] mem_data
);

    // Drive only when enabled; otherwise release the bus.
    assign mem_data = oe ? dout : {DWIDTH{1'bz}};

    // Whatever is on the bus, including an undriven or X value, passes through.
    assign din = mem_data;

endmodule

// File: rtl/memory_ctrl.sv
// Sequencer for the 32-entry async-strobe memory array on a shared data bus.
// Optional statistics counters are enabled with `define MEMORY_CTRL_STATS_EN.
module memory_ctrl
    import memory_pkg::*;
#(
    parameter int unsigned DWIDTH   = MEM_DWIDTH,
    parameter int unsigned AWIDTH   = MEM_AWIDTH,
    parameter int unsigned RD_WAIT  = 1,
    parameter int unsigned WR_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    memory_ctrl_if.slave      host,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    inout  wire  [DWIDTH-1:0] mem_data
`ifdef MEMORY_CTRL_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt
`endif
);

    localparam int unsigned CNT_MAX = max_u(RD_WAIT, WR_PULSE);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    mem_ctrl_state_t   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              oe_q, oe_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic [DWIDTH-1:0] din;

    mem_bus_io #(
        .DWIDTH (DWIDTH)
    ) u_bus_io (
        .oe       (oe_q),
        .dout     (dout_q),
        .din      (din),
        .mem_data (mem_data)
    );

    // Next state and next registered outputs; strobes and bus enable default low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        dout_d      = dout_q;
        rdata_d     = rdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        oe_d        = 1'b0;
        rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host.req_valid && req_ready_q) begin
                    mem_addr_d = host.req_addr;
                    if (host.req_we) begin
                        dout_d  = host.req_wdata;
                        oe_d    = 1'b1;
                        state_d = ST_WR_SETUP;
                    end else begin
                        mem_read_d = 1'b1;
                        cnt_d      = CNT_W'(RD_WAIT);
                        state_d    = ST_RD_ACTIVE;
                    end
                end
            end
            ST_WR_SETUP: begin
                oe_d        = 1'b1;
                mem_write_d = 1'b1;
                cnt_d       = CNT_W'(WR_PULSE - 1);
                state_d     = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                oe_d = 1'b1;
                if (cnt_q != '0) begin
                    mem_write_d = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_RD_ACTIVE: begin
                if (cnt_q != '0) begin
                    mem_read_d = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d     = din;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops strobes and releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            dout_q      <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            dout_q      <= dout_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign host.req_ready = req_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;

`ifdef MEMORY_CTRL_STATS_EN
    logic [15:0] stat_rd_q, stat_rd_d;
    logic [15:0] stat_wr_q, stat_wr_d;

    // Saturating completion counters; clear wins over increment.
    always_comb begin
        stat_rd_d = stat_rd_q;
        stat_wr_d = stat_wr_q;
        if (stat_clr) begin
            stat_rd_d = '0;
            stat_wr_d = '0;
        end else begin
            if (rsp_valid_d && (state_q == ST_RD_ACTIVE) && (stat_rd_q != 16'hFFFF)) begin
                stat_rd_d = stat_rd_q + 16'd1;
            end
            if (rsp_valid_d && (state_q == ST_WR_HOLD) && (stat_wr_q != 16'hFFFF)) begin
                stat_wr_d = stat_wr_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`endif

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl with a behavioural async-strobe memory array.
module tb_memory_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] mem_addr;
    logic       mem_read;
    logic       mem_write;
    wire  [7:0] mem_data;
`ifdef MEMORY_CTRL_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
`endif

    memory_ctrl_if #(.DWIDTH(8), .AWIDTH(5)) host_if ();

    memory_ctrl #(
        .DWIDTH   (8),
        .AWIDTH   (5),
        .RD_WAIT  (1),
        .WR_PULSE (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host_if.slave),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_data  (mem_data)
`ifdef MEMORY_CTRL_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt)
`endif
    );

    typedef struct {
        logic       we;
        logic [7:0] exp;
        int         acc;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mem_arr[32];
    logic [7:0] sb_mem[32];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         wr_hi_cnt = 0;
    int         rd_hi_cnt = 0;
    int         wr_rise_cnt = 0;
    int         rd_rise_cnt = 0;
    logic       wr_prev = 1'b0;
    logic       rd_prev = 1'b0;
    logic [4:0] exp_addr = '0;
    logic [7:0] exp_wdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory array: read data driven while mem_read is high, write on mem_write rise.
    assign mem_data = mem_read ? mem_arr[mem_addr] : 8'bz;
    always @(posedge mem_write) if (!mem_read) mem_arr[mem_addr] <= mem_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus invariants and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read && mem_write) chk("rd_wr_excl", 32'(1), 32'(0));
            if (mem_read) chk("turnaround", 32'(dut.oe_q), 32'(0));
            if (dut.oe_q) begin
                chk("wr_addr", 32'(mem_addr), 32'(exp_addr));
                chk("wr_data", 32'(mem_data), 32'(exp_wdata));
            end
            if (mem_write) wr_hi_cnt++;
            if (mem_read) rd_hi_cnt++;
            if (mem_write && !wr_prev) wr_rise_cnt++;
            if (mem_read && !rd_prev) rd_rise_cnt++;
            wr_prev = mem_write;
            rd_prev = mem_read;
            if (host_if.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_rsp", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk(e.we ? "wr_latency" : "rd_latency", 32'(cyc - e.acc), e.we ? 32'(3) : 32'(2));
                    if (!e.we) chk("rsp_rdata", 32'(host_if.rsp_rdata), 32'(e.exp));
                end
            end
        end else begin
            wr_prev = 1'b0;
            rd_prev = 1'b0;
        end
    end

    // Present a request at a negedge, wait for acceptance, record the expectation.
    task automatic send(input logic we, input logic [4:0] addr, input logic [7:0] data,
                        input bit keep, output logic rsp_at_acc);
        int n = 0;
        exp_t e;
        host_if.req_valid = 1'b1;
        host_if.req_we    = we;
        host_if.req_addr  = addr;
        host_if.req_wdata = data;
        while (!host_if.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        rsp_at_acc = host_if.rsp_valid;
        if (!host_if.req_ready) begin
            chk("accept_timeout", 32'(0), 32'(1));
            host_if.req_valid = 1'b0;
            return;
        end
        if (we) begin
            exp_addr  = addr;
            exp_wdata = data;
        end
        @(posedge clk);
        #1;
        e.we  = we;
        e.exp = we ? data : sb_mem[addr];
        e.acc = cyc;
        if (we) sb_mem[addr] = data;
        sb_q.push_back(e);
        @(negedge clk);
        if (!keep) host_if.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) chk("rsp_timeout", 32'(sb_q.size()), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        logic r;
        int   w0, r0, wr0, rr0;
        for (int i = 0; i < 32; i++) begin
            mem_arr[i] = 8'(8'h40 + i);
            sb_mem[i]  = 8'(8'h40 + i);
        end
        host_if.req_valid = 1'b0;
        host_if.req_we    = 1'b0;
        host_if.req_addr  = '0;
        host_if.req_wdata = '0;
`ifdef MEMORY_CTRL_STATS_EN
        stat_clr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_req_ready", 32'(host_if.req_ready), 32'(1));
        chk("rst_rsp_valid", 32'(host_if.rsp_valid), 32'(0));
        chk("rst_rsp_rdata", 32'(host_if.rsp_rdata), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_read", 32'(mem_read), 32'(0));
        chk("rst_mem_write", 32'(mem_write), 32'(0));
        chk("rst_oe", 32'(dut.oe_q), 32'(0));

        // Single write: one strobe of one cycle.
        w0 = wr_hi_cnt; wr0 = wr_rise_cnt;
        send(1'b1, 5'd3, 8'hA5, 1'b0, r);
        wait_done();
        chk("wr_pulse_cycles", 32'(wr_hi_cnt - w0), 32'(1));
        chk("wr_pulse_rises", 32'(wr_rise_cnt - wr0), 32'(1));
        chk("mem_a5", 32'(mem_arr[3]), 32'(8'hA5));
        chk("rdata_hold_init", 32'(host_if.rsp_rdata), 32'(0));

        // Read back: mem_read held two cycles.
        r0 = rd_hi_cnt;
        send(1'b0, 5'd3, 8'h00, 1'b0, r);
        wait_done();
        chk("rd_strobe_cycles", 32'(rd_hi_cnt - r0), 32'(2));

        // Back-to-back read then write with req_valid held high.
        send(1'b0, 5'd0, 8'h00, 1'b1, r);
        send(1'b1, 5'd31, 8'h3C, 1'b0, r);
        chk("b2b_acc_in_rsp", 32'(r), 32'(1));
        wait_done();
        send(1'b0, 5'd31, 8'h00, 1'b0, r);
        wait_done();
        chk("rdata_hold_wr", 32'(host_if.rsp_rdata), 32'(8'h3C));
        send(1'b1, 5'd5, 8'h77, 1'b0, r);
        wait_done();
        chk("rdata_hold_after_wr", 32'(host_if.rsp_rdata), 32'(8'h3C));

        // Toggle req_valid while a write is in flight.
        rr0 = rd_rise_cnt; wr0 = wr_rise_cnt;
        send(1'b1, 5'd10, 8'h5A, 1'b0, r);
        host_if.req_valid = 1'b1;
        host_if.req_we    = 1'b0;
        host_if.req_addr  = 5'd1;
        @(negedge clk);
        chk("strobe_ready", 32'(host_if.req_ready), 32'(0));
        chk("strobe_write", 32'(mem_write), 32'(1));
        host_if.req_valid = 1'b0;
        #2 host_if.req_valid = 1'b1;
        @(negedge clk);
        chk("hold_ready", 32'(host_if.req_ready), 32'(0));
        host_if.req_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("toggle_no_rd", 32'(rd_rise_cnt - rr0), 32'(0));
        chk("toggle_one_wr", 32'(wr_rise_cnt - wr0), 32'(1));

        // Reset during WR_SETUP: no strobe, bus released, memory untouched.
        exp_addr  = 5'd7;
        exp_wdata = 8'hEE;
        host_if.req_valid = 1'b1;
        host_if.req_we    = 1'b1;
        host_if.req_addr  = 5'd7;
        host_if.req_wdata = 8'hEE;
        @(posedge clk);
        #1 host_if.req_valid = 1'b0;
        chk("setup_oe", 32'(dut.oe_q), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_write", 32'(mem_write), 32'(0));
        chk("rst_mid_oe", 32'(dut.oe_q), 32'(0));
        chk("rst_mid_rsp", 32'(host_if.rsp_valid), 32'(0));
        repeat (2) @(negedge clk);
        chk("rst_mem_kept", 32'(mem_arr[7]), 32'(sb_mem[7]));
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 5'd7, 8'h00, 1'b0, r);
        wait_done();

`ifdef MEMORY_CTRL_STATS_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 5'(12 + i), 8'(8'h10 + i), 1'b0, r);
            wait_done();
        end
        for (int i = 0; i < 2; i++) begin
            send(1'b0, 5'(12 + i), 8'h00, 1'b0, r);
            wait_done();
        end
        chk("stat_wr", 32'(stat_wr_cnt), 32'(3));
        chk("stat_rd", 32'(stat_rd_cnt), 32'(2));
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_wr_clr", 32'(stat_wr_cnt), 32'(0));
        chk("stat_rd_clr", 32'(stat_rd_cnt), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
